// File: rtl/dma_pkg.sv
// Shared definitions for the RAM-to-DMA bridge.
//   state_t  : bridge FSM states
//   RAM_WORD_WID / BUS_DATA_WID : loader halfword and bus word widths
//   sel_half : little-endian halfword select from a bus word
package dma_pkg;

    localparam int RAM_WORD_WID = 16;
    localparam int BUS_DATA_WID = 2 * RAM_WORD_WID;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // hi=0 -> low halfword (lower byte address), hi=1 -> upper halfword
    function automatic logic [RAM_WORD_WID-1:0] sel_half(
        input logic [BUS_DATA_WID-1:0] line,
        input logic                    hi
    );
        return hi ? line[BUS_DATA_WID-1:RAM_WORD_WID] : line[RAM_WORD_WID-1:0];
    endfunction

endpackage

// File: rtl/dma_line_cache.sv
// One-line cache holding the last fetched bus word.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   flush             : invalidate the line; also forces the current lookup to miss
//   inval             : invalidate the line (aborted fill)
//   wr_en/wr_tag/wr_data : install a freshly fetched word
//   lookup_tag        : tag of the word being requested
//   hit               : line valid and tag matches (and no flush this cycle)
//   data              : cached word
module dma_line_cache #(
    parameter int TAG_WID  = 30,
    parameter int DATA_WID = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                inval,
    input  logic                wr_en,
    input  logic [TAG_WID-1:0]  wr_tag,
    input  logic [DATA_WID-1:0] wr_data,
    input  logic [TAG_WID-1:0]  lookup_tag,
    output logic                hit,
    output logic [DATA_WID-1:0] data
);

    logic               valid;
    logic [TAG_WID-1:0] tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (flush || inval)
                valid <= 1'b0;
            else if (wr_en)
                valid <= 1'b1;
            if (wr_en) begin
                tag  <= wr_tag;
                data <= wr_data;
            end
        end
    end

    // A flush arriving in the same cycle as the lookup wins: treat as miss.
    assign hit = valid && (tag == lookup_tag) && !flush;

endmodule

// File: rtl/ram_dma_bridge.sv
// Bridge between the waveform loader's halfword request interface and a
// 32-bit SoC memory port, with a one-line cache so both halfwords of a
// word cost a single bus read.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   ram_dma_addr, ram_read  : loader byte address and request level
//   ram_word, ram_valid     : returned halfword and one-cycle completion pulse
//   flush                   : invalidate the cache line and clear err
//   mem_addr, mem_req       : word-aligned physical address, request held until ack
//   mem_ack, mem_rdata      : bus completion and read data (same cycle)
//   err                     : sticky error (ack timeout or odd address)
module ram_dma_bridge #(
    parameter int                 RAM_WID        = 32,
    parameter int                 RAM_WORD_WID   = 16,
    parameter int                 BUS_DATA_WID   = 32,
    parameter logic [RAM_WID-1:0] RAM_REAL_START = '0,
    parameter int                 TIMEOUT_WID    = 16,
    parameter int                 TIMEOUT        = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RAM_WID-1:0]      ram_dma_addr,
    input  logic                    ram_read,
    output logic [RAM_WORD_WID-1:0] ram_word,
    output logic                    ram_valid,
    input  logic                    flush,
    output logic [RAM_WID-1:0]      mem_addr,
    output logic                    mem_req,
    input  logic                    mem_ack,
    input  logic [BUS_DATA_WID-1:0] mem_rdata,
    output logic                    err
);
    // Imported after the parameters so the local width parameters take
    // precedence; sel_half assumes BUS_DATA_WID == 2*RAM_WORD_WID.
    import dma_pkg::*;

    localparam int TAG_WID = RAM_WID - 2;

    state_t                  state;
    logic [TIMEOUT_WID-1:0]  cnt;
    logic [TIMEOUT_WID-1:0]  cnt_nxt;
    logic [BUS_DATA_WID-1:0] resp_data;
    logic                    resp_zero;   // respond with 0 (error path)
    logic                    resp_hi;     // upper halfword requested
    logic                    fill_kill;   // flush seen during this fill
    logic [TAG_WID-1:0]      req_tag;
    logic                    hit;
    logic [BUS_DATA_WID-1:0] line_data;
    logic                    in_bus;
    logic                    tmo;
    logic                    fill_wr;

    assign req_tag = ram_dma_addr[RAM_WID-1:2];
    assign in_bus  = (state == ST_BUS);
    assign cnt_nxt = cnt + TIMEOUT_WID'(1);
    assign tmo     = in_bus && !mem_ack && (cnt_nxt == TIMEOUT_WID'(TIMEOUT));
    // A fill is dropped from the cache if any flush touched it in flight.
    assign fill_wr = in_bus && mem_ack && !fill_kill && !flush;

    dma_line_cache #(
        .TAG_WID  (TAG_WID),
        .DATA_WID (BUS_DATA_WID)
    ) u_line (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .inval      (tmo),
        .wr_en      (fill_wr),
        .wr_tag     (req_tag),
        .wr_data    (mem_rdata),
        .lookup_tag (req_tag),
        .hit        (hit),
        .data       (line_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            resp_data <= '0;
            resp_zero <= 1'b0;
            resp_hi   <= 1'b0;
            fill_kill <= 1'b0;
            ram_word  <= '0;
            ram_valid <= 1'b0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_valid <= 1'b0;
            // Error events below are later assignments and win over a
            // coincident flush.
            if (flush)
                err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ram_read) begin
                        resp_hi <= ram_dma_addr[1];
                        cnt     <= '0;
                        if (ram_dma_addr[0]) begin
                            err       <= 1'b1;
                            resp_zero <= 1'b1;
                            state     <= ST_RESP;
                        end else if (hit) begin
                            resp_data <= line_data;
                            resp_zero <= 1'b0;
                            state     <= ST_RESP;
                        end else begin
                            mem_addr  <= RAM_REAL_START + {req_tag, 2'b00};
                            mem_req   <= 1'b1;
                            fill_kill <= 1'b0;
                            resp_zero <= 1'b0;
                            state     <= ST_BUS;
                        end
                    end
                end

                ST_BUS: begin
                    if (flush)
                        fill_kill <= 1'b1;
                    if (mem_ack) begin
                        resp_data <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (tmo) begin
                        mem_req   <= 1'b0;
                        err       <= 1'b1;
                        resp_zero <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end

                ST_RESP: begin
                    ram_valid <= 1'b1;
                    ram_word  <= resp_zero ? '0 : sel_half(resp_data, resp_hi);
                    state     <= ST_DROP;
                end

                ST_DROP: begin
                    // Wait for the loader to release the request so a held
                    // level never completes twice.
                    if (!ram_read)
                        state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dma_bridge.sv
// Directed bench for ram_dma_bridge: cold miss, hit, odd address, flush,
// flush during a fill, ack timeout, full sweep against a model memory,
// and asynchronous reset during a bus transaction.
module tb_ram_dma_bridge;

    localparam logic [31:0] START = 32'h1000_0000;
    localparam int          TMO   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ram_dma_addr;
    logic        ram_read;
    logic [15:0] ram_word;
    logic        ram_valid;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    ram_dma_bridge #(
        .RAM_WID        (32),
        .RAM_WORD_WID   (16),
        .BUS_DATA_WID   (32),
        .RAM_REAL_START (START),
        .TIMEOUT_WID    (16),
        .TIMEOUT        (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ram_dma_addr (ram_dma_addr),
        .ram_read     (ram_read),
        .ram_word     (ram_word),
        .ram_valid    (ram_valid),
        .flush        (flush),
        .mem_addr     (mem_addr),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Responder / monitor state
    bit          ack_en     = 1'b1;
    int          ack_delay  = 0;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_data = 32'h0;
    int          wait_cnt   = 0;
    int          req_cnt    = 0;
    int          req_hi     = 0;
    int          valid_cnt  = 0;
    bit          req_prev   = 1'b0;
    logic [31:0] last_addr  = 32'h0;
    int          lat;

    function automatic logic [31:0] model(input logic [31:0] pa);
        return pa ^ {pa[15:0], pa[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Memory-side responder and bus monitor, all on the falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (ram_valid) valid_cnt++;
            if (mem_req) begin
                req_hi++;
                if (!req_prev) begin
                    req_cnt++;
                    last_addr = mem_addr;
                end
            end
            req_prev = mem_req;
            if (mem_req && ack_en) begin
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = use_fixed ? fixed_data : model(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic start_read(input logic [31:0] a);
        @(negedge clk);
        ram_dma_addr = a;
        ram_read     = 1'b1;
        lat          = 0;
    endtask

    // Waits (bounded) for ram_valid, returns the word, releases the request.
    task automatic finish_read(output logic [15:0] w);
        do begin
            @(negedge clk);
            lat++;
        end while (!ram_valid && lat < 200);
        chk("valid_seen", ram_valid, 1'b1);
        w        = ram_word;
        ram_read = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [15:0] w);
        start_read(a);
        finish_read(w);
    endtask

    logic [15:0] w;
    logic [31:0] exp_w;
    int          r0, v0;

    initial begin
        rst_n        = 1'b0;
        ram_dma_addr = 32'h0;
        ram_read     = 1'b0;
        flush        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ram_valid", ram_valid, 1'b0);
        chk("rst_mem_req",   mem_req,   1'b0);
        chk("rst_err",       err,       1'b0);
        chk("rst_ram_word",  ram_word,  16'h0);
        chk("rst_mem_addr",  mem_addr,  32'h0);
        rst_n = 1'b1;

        // Cold read, ack after 3 cycles of mem_req
        use_fixed = 1'b1; fixed_data = 32'hBEEF_1234; ack_delay = 2;
        r0 = req_cnt; req_hi = 0; v0 = valid_cnt;
        do_read(32'h10, w);
        chk("cold_word",    w,              16'h1234);
        chk("cold_lat",     lat,            5);
        chk("cold_reqs",    req_cnt - r0,   1);
        chk("cold_req_hi",  req_hi,         3);
        chk("cold_addr",    last_addr,      START + 32'h10);
        @(negedge clk);
        chk("cold_vpulse",  valid_cnt - v0, 1);
        chk("word_hold",    ram_word,       16'h1234);
        use_fixed = 1'b0;

        // Hit on the other halfword
        r0 = req_cnt;
        do_read(32'h12, w);
        chk("hit_word",  w,            16'hBEEF);
        chk("hit_lat",   lat,          2);
        chk("hit_reqs",  req_cnt - r0, 0);

        // Odd address: error, zero, no bus
        r0 = req_cnt;
        do_read(32'h11, w);
        chk("odd_word",  w,            16'h0);
        chk("odd_err",   err,          1'b1);
        chk("odd_reqs",  req_cnt - r0, 0);
        chk("odd_lat",   lat,          2);

        // Line survives the odd request
        do_read(32'h10, w);
        chk("after_odd_hit", w,            16'h1234);
        chk("after_odd_req", req_cnt - r0, 0);

        // Flush clears err and invalidates
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_err", err, 1'b0);
        ack_delay = 0; r0 = req_cnt;
        do_read(32'h12, w);
        exp_w = model(START + 32'h10);
        chk("flush_miss_req",  req_cnt - r0, 1);
        chk("flush_miss_word", w,            exp_w[31:16]);
        chk("flush_miss_lat",  lat,          3);

        // Flush during a fill: data returned, not cached
        ack_delay = 3; r0 = req_cnt;
        start_read(32'h20);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        lat = 2;
        finish_read(w);
        exp_w = model(START + 32'h20);
        chk("fbus_word", w, exp_w[15:0]);
        ack_delay = 0;
        do_read(32'h22, w);
        chk("fbus_refetch", req_cnt - r0, 2);
        chk("fbus_word2",   w,            exp_w[31:16]);

        // Ack timeout
        ack_en = 1'b0; r0 = req_cnt; req_hi = 0;
        do_read(32'h50, w);
        chk("tmo_req_hi", req_hi,  TMO);
        chk("tmo_lat",    lat,     TMO + 2);
        chk("tmo_word",   w,       16'h0);
        chk("tmo_err",    err,     1'b1);
        ack_en = 1'b1;
        do_read(32'h50, w);
        exp_w = model(START + 32'h50);
        chk("tmo_reissue",  req_cnt - r0, 2);
        chk("tmo_word2",    w,            exp_w[15:0]);
        chk("tmo_err_stky", err,          1'b1);

        // Sweep 4094 halfwords against the model memory
        r0 = req_cnt;
        for (int i = 0; i < 4094; i++) begin
            logic [31:0] a;
            a = 32'h1000 + 32'(2 * i);
            do_read(a, w);
            exp_w = model(START + {a[31:2], 2'b00});
            chk("sweep_word", w, a[1] ? exp_w[31:16] : exp_w[15:0]);
        end
        chk("sweep_reqs", req_cnt - r0, 2047);

        // Async reset during BUS
        do_read(32'h30, w);
        ack_en = 1'b0;
        start_read(32'h40);
        @(negedge clk); @(negedge clk);
        chk("rst_bus_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_bus_req",   mem_req,   1'b0);
        chk("rst_bus_valid", ram_valid, 1'b0);
        chk("rst_bus_err",   err,       1'b0);
        ram_read = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        r0 = req_cnt;
        do_read(32'h30, w);
        exp_w = model(START + 32'h30);
        chk("rst_miss_req",  req_cnt - r0, 1);
        chk("rst_miss_word", w,            exp_w[15:0]);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
